// File: rtl/dma_channel.sv
// Single-channel DMA engine: copies a block of halfword or word units from a
// source to a destination address, one bus read then one bus write per unit.
`ifndef MEM_SIZE_HALF
`define MEM_SIZE_HALF 2'b01
`endif
`ifndef MEM_SIZE_WORD
`define MEM_SIZE_WORD 2'b10
`endif

module dma_channel #(
  parameter int COUNT_W = 14
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        cfg_src,
  input  logic [31:0]        cfg_dst,
  input  logic [COUNT_W-1:0] cfg_count,
  input  logic               cfg_word,
  input  logic [1:0]         cfg_src_ctl,
  input  logic [1:0]         cfg_dst_ctl,
  output logic               busy,
  output logic               done,
  output logic               bus_req,
  input  logic               bus_grant,
  output logic [31:0]        bus_addr,
  output logic [1:0]         bus_size,
  output logic               bus_write,
  output logic [31:0]        bus_wdata,
  input  logic [31:0]        bus_rdata,
  input  logic               bus_pause
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WDATA,
    S_DONE
  } state_t;

  state_t             state;
  logic [31:0]        src;
  logic [31:0]        dst;
  logic [COUNT_W:0]   remaining;
  logic               word;
  logic [1:0]         src_ctl;
  logic [1:0]         dst_ctl;

  logic [31:0]        step;
  logic [31:0]        src_next;
  logic [31:0]        dst_next;
  logic [31:0]        align_mask;
  logic [31:0]        cfg_src_al;
  logic [31:0]        cfg_dst_al;
  logic [15:0]        rd_half;

  always_comb begin
    step = word ? 32'd4 : 32'd2;
    case (src_ctl)
      2'b00:   src_next = src + step;
      2'b01:   src_next = src - step;
      default: src_next = src;
    endcase
    // dst_ctl 11 behaves as increment, unlike src_ctl where 11 is fixed
    case (dst_ctl)
      2'b01:   dst_next = dst - step;
      2'b10:   dst_next = dst;
      default: dst_next = dst + step;
    endcase
    align_mask = cfg_word ? 32'hFFFF_FFFC : 32'hFFFF_FFFE;
    cfg_src_al = cfg_src & align_mask;
    cfg_dst_al = cfg_dst & align_mask;
    rd_half    = src[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  end

  // bus_wdata doubles as the data latch between the read and write phases
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      bus_req   <= 1'b0;
      done      <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_size  <= `MEM_SIZE_WORD;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      word      <= 1'b1;
      src_ctl   <= 2'b00;
      dst_ctl   <= 2'b00;
    end else if (!bus_pause) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src       <= cfg_src_al;
            dst       <= cfg_dst_al;
            word      <= cfg_word;
            src_ctl   <= cfg_src_ctl;
            dst_ctl   <= cfg_dst_ctl;
            remaining <= (cfg_count == '0) ? {1'b1, {COUNT_W{1'b0}}} : {1'b0, cfg_count};
            bus_size  <= cfg_word ? `MEM_SIZE_WORD : `MEM_SIZE_HALF;
            bus_addr  <= cfg_src_al;
            busy      <= 1'b1;
            bus_req   <= 1'b1;
            state     <= S_RADDR;
          end
        end
        S_RADDR: begin
          if (bus_grant) state <= S_RDATA;
        end
        S_RDATA: begin
          bus_wdata <= word ? bus_rdata : {rd_half, rd_half};
          bus_addr  <= dst;
          bus_write <= 1'b1;
          state     <= S_WADDR;
        end
        S_WADDR: begin
          bus_write <= 1'b0;
          state     <= S_WDATA;
        end
        S_WDATA: begin
          src       <= src_next;
          dst       <= dst_next;
          remaining <= remaining - (COUNT_W+1)'(1);
          if (remaining == (COUNT_W+1)'(1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            bus_addr <= src_next;
            state    <= S_RADDR;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          bus_req <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_channel.sv
// Bench for dma_channel: bus memory model, transfer-level reference model and
// a per-cycle compare process, driven by directed transfers.
module tb_dma_channel;
  localparam int CW = 3;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   cfg_src = '0;
  logic [31:0]   cfg_dst = '0;
  logic [CW-1:0] cfg_count = '0;
  logic          cfg_word = 1'b0;
  logic [1:0]    cfg_src_ctl = '0;
  logic [1:0]    cfg_dst_ctl = '0;
  logic          busy, done, bus_req, bus_write;
  logic          bus_grant = 1'b1;
  logic          bus_pause = 1'b0;
  logic [31:0]   bus_addr, bus_wdata;
  logic [31:0]   bus_rdata = '0;
  logic [1:0]    bus_size;

  dma_channel #(.COUNT_W(CW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_count(cfg_count),
    .cfg_word(cfg_word), .cfg_src_ctl(cfg_src_ctl), .cfg_dst_ctl(cfg_dst_ctl),
    .busy(busy), .done(done), .bus_req(bus_req), .bus_grant(bus_grant),
    .bus_addr(bus_addr), .bus_size(bus_size), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_pause(bus_pause)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory: read data appears in the cycle after the address phase
  bit [31:0] mem [bit [29:0]];

  function automatic bit [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return 32'h0;
  endfunction

  always @(posedge clock) begin
    bit [31:0] w;
    if (chk_en && !bus_pause) begin
      bus_rdata <= rd_word(bus_addr);
      if (bus_write) begin
        w = rd_word(bus_addr);
        if (bus_size == SZ_WORD) w = bus_wdata;
        else if (bus_addr[1]) w[31:16] = bus_wdata[31:16];
        else w[15:0] = bus_wdata[15:0];
        mem[bus_addr[31:2]] = w;
      end
    end
  end

  // Reference model: list of expected writes plus the busy/done window
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  int exp_lo = 1, exp_hi = 0, exp_done = -1, start_cyc = 0;
  logic [1:0] exp_size = SZ_WORD;

  task automatic model_start(input logic [31:0] s, input logic [31:0] d, input int cnt,
                             input bit w, input logic [1:0] sc, input logic [1:0] dc,
                             input int delay);
    int n, st;
    logic [31:0] sa, da, wd;
    logic [15:0] h;
    n  = (cnt == 0) ? (1 << CW) : cnt;
    st = w ? 4 : 2;
    sa = w ? {s[31:2], 2'b00} : {s[31:1], 1'b0};
    da = w ? {d[31:2], 2'b00} : {d[31:1], 1'b0};
    for (int i = 0; i < n; i++) begin
      wd = rd_word(sa);
      if (!w) begin
        h  = sa[1] ? wd[31:16] : wd[15:0];
        wd = {h, h};
      end
      exp_q.push_back('{addr: da, data: wd});
      sa = (sc == 2'b00) ? sa + st : (sc == 2'b01) ? sa - st : sa;
      da = (dc == 2'b01) ? da - st : (dc == 2'b10) ? da : da + st;
    end
    exp_size  = w ? SZ_WORD : SZ_HALF;
    start_cyc = cyc;
    exp_lo    = cyc + 1;
    exp_done  = cyc + 4 * n + 1 + delay;
    exp_hi    = exp_done;
  endtask

  int done_rel = -1;
  int wr_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic p_pause = 1'b0, p_write = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [1:0] p_size = '0;

  always @(negedge clock) begin
    bit eb;
    wr_t e;
    if (chk_en) begin
      eb = (cyc >= exp_lo) && (cyc <= exp_hi);
      check("busy", busy, 32'(eb));
      check("bus_req", bus_req, 32'(eb));
      check("done", done, 32'(cyc == exp_done));
      if (done) done_rel = cyc - start_cyc;
      if (p_pause) begin
        check("pause_addr", bus_addr, p_addr);
        check("pause_wdata", bus_wdata, p_wdata);
        check("pause_write", bus_write, p_write);
        check("pause_size", bus_size, p_size);
      end
      if (!eb) check("idle_write", bus_write, 0);
      if (bus_write && !bus_pause) begin
        wr_cnt++;
        last_wdata = bus_wdata;
        if (exp_q.size() == 0) begin
          check("unexpected_write", bus_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus_addr, e.addr);
          check("wr_data", bus_wdata, e.data);
          check("wr_size", bus_size, exp_size);
        end
      end
      p_pause = bus_pause;
      p_write = bus_write;
      p_addr  = bus_addr;
      p_wdata = bus_wdata;
      p_size  = bus_size;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go(input logic [31:0] s, input logic [31:0] d, input int cnt, input bit w,
                    input logic [1:0] sc, input logic [1:0] dc, input int delay);
    cfg_src = s; cfg_dst = d; cfg_count = CW'(cnt); cfg_word = w;
    cfg_src_ctl = sc; cfg_dst_ctl = dc;
    done_rel = -1;
    wr_cnt = 0;
    start = 1'b1;
    model_start(s, d, cnt, w, sc, dc, delay);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    for (int i = 0; i < 200 && cyc < start_cyc + r; i++) tick();
  endtask

  task automatic wait_end();
    for (int i = 0; i < 300 && cyc <= exp_done + 1; i++) tick();
    check("leftover_writes", exp_q.size(), 0);
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", bus_write, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_size", bus_size, SZ_WORD);
    reset = 1'b0;
    tick();

    // Word increment copy
    mem[30'h00C0_0000] = 32'hDEAD_BEEF;
    mem[30'h00C0_0001] = 32'hCAFE_F00D;
    mem[30'h00C0_0002] = 32'hBA5E_BA11;
    go(32'h0300_0000, 32'h0200_0000, 3, 1'b1, 2'b00, 2'b00, 0);
    wait_end();
    check("w_done_cycle", done_rel, 13);
    check("w_writes", wr_cnt, 3);
    check("w_dst0", rd_word(32'h0200_0000), 32'hDEAD_BEEF);
    check("w_dst1", rd_word(32'h0200_0004), 32'hCAFE_F00D);
    check("w_dst2", rd_word(32'h0200_0008), 32'hBA5E_BA11);

    // Halfword decrement source, fixed destination
    mem[30'h00C0_0000] = 32'h2222_1111;
    mem[30'h00C0_0001] = 32'h4444_3333;
    mem[30'h0100_0000] = 32'h0;
    go(32'h0300_0006, 32'h0400_0000, 4, 1'b0, 2'b01, 2'b10, 0);
    wait_end();
    check("h_done_cycle", done_rel, 17);
    check("h_last_wdata", last_wdata, 32'h1111_1111);
    check("h_dst", rd_word(32'h0400_0000), 32'h0000_1111);

    // Pause during WADDR of unit 1 and RDATA of unit 2
    mem[30'h00C0_0000] = 32'h1122_3344;
    mem[30'h00C0_0001] = 32'h5566_7788;
    go(32'h0300_0000, 32'h0200_0100, 2, 1'b1, 2'b00, 2'b00, 6);
    wait_rel(3);
    bus_pause = 1'b1;
    repeat (3) tick();
    bus_pause = 1'b0;
    wait_rel(9);
    bus_pause = 1'b1;
    repeat (3) tick();
    bus_pause = 1'b0;
    wait_end();
    check("p_done_cycle", done_rel, 15);
    check("p_dst0", rd_word(32'h0200_0100), 32'h1122_3344);
    check("p_dst1", rd_word(32'h0200_0104), 32'h5566_7788);

    // Grant withheld for the first 5 RADDR cycles
    bus_grant = 1'b0;
    go(32'h0300_0000, 32'h0200_0200, 1, 1'b1, 2'b00, 2'b00, 5);
    wait_rel(3);
    check("g_hold_addr", bus_addr, 32'h0300_0000);
    check("g_hold_write", bus_write, 0);
    wait_rel(6);
    bus_grant = 1'b1;
    wait_end();
    check("g_done_cycle", done_rel, 10);
    check("g_dst", rd_word(32'h0200_0200), 32'h1122_3344);

    // Count 0 moves 2^CW units; unaligned word source
    for (int i = 0; i < 8; i++) mem[30'h00C0_0000 + 30'(i)] = 32'hA000_0000 + 32'(i);
    go(32'h0300_0003, 32'h0500_0000, 0, 1'b1, 2'b00, 2'b00, 0);
    wait_end();
    check("c0_done_cycle", done_rel, 33);
    check("c0_writes", wr_cnt, 8);
    check("c0_dst0", rd_word(32'h0500_0000), 32'hA000_0000);
    check("c0_dst7", rd_word(32'h0500_001C), 32'hA000_0007);

    // Reset during the second unit's WADDR
    mem[30'h00C0_0000] = 32'h1122_3344;
    mem[30'h00C0_0001] = 32'h5566_7788;
    go(32'h0300_0000, 32'h0200_0300, 2, 1'b1, 2'b00, 2'b00, 0);
    wait_rel(7);
    @(negedge clock);
    #1;
    reset = 1'b1;
    exp_hi = cyc;
    exp_done = -1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    check("r_busy", busy, 0);
    check("r_write", bus_write, 0);
    check("r_done", done, 0);
    check("r_kept_write", rd_word(32'h0200_0304), 32'h5566_7788);
    repeat (4) tick();
    go(32'h0300_0000, 32'h0200_0400, 2, 1'b1, 2'b00, 2'b00, 0);
    wait_end();
    check("r_clean_done", done_rel, 9);
    check("r_clean_dst1", rd_word(32'h0200_0404), 32'h5566_7788);

    // start while busy is ignored
    go(32'h0300_0000, 32'h0200_0500, 2, 1'b1, 2'b00, 2'b00, 0);
    wait_rel(3);
    cfg_src = 32'h0300_0004; cfg_dst = 32'h0600_0000; cfg_count = CW'(1);
    cfg_word = 1'b0; cfg_src_ctl = 2'b10; cfg_dst_ctl = 2'b01;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_end();
    check("sb_done_cycle", done_rel, 9);
    check("sb_writes", wr_cnt, 2);
    check("sb_dst1", rd_word(32'h0200_0504), 32'h5566_7788);

    // start together with reset stays idle
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("sr_busy", busy, 0);
    repeat (3) tick();
    check("sr_busy_later", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
